fib_mem_sequencer: RTL and testbench
====================================

Name: fib_mem_sequencer

Overview:
- Computes a Fibonacci sequence inside one 1K-word bank of the dual-port 32K x 16 block RAM.
- Seeds the first two words, then repeatedly reads the previous two terms (one per port), adds them, and writes the sum to the next address.
- Sits on the same RAM ports (addr0/addr1, w0/w1, data0/data1, q0/q1) as the bank-fill sequencer. Its start/done handshake lets the top-level mux hand the RAM between the two.

Parameters:
- NUM_TERMS, 25, total words written including both seeds; legal range 3..1024. Default ends at F(24)=46368.
- SEED0, 16'd0, value written at bank offset 0.
- SEED1, 16'd1, value written at bank offset 1.

Ports:
- clk  in  1  system clock; all internal registers update on the falling edge; the RAM samples on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled on the falling edge while IDLE; ignored otherwise.
- bank  in  5  RAM bank select (address bits [14:10]); captured into bank_r when start is accepted.
- q0  in  16  RAM port-0 read data; valid after the rising edge following the address.
- q1  in  16  RAM port-1 read data.
- addr0  out  15  RAM port-0 address.
- addr1  out  15  RAM port-1 address.
- w0  out  1  RAM port-0 write enable.
- w1  out  1  RAM port-1 write enable.
- data0  out  16  RAM port-0 write data.
- data1  out  16  RAM port-1 write data.
- busy  out  1  high in SEED, READ and WRITE.
- done  out  1  one-cycle pulse in DONE.
- overflow  out  1  sticky; set when a sum exceeds 16 bits; cleared when start is accepted.
- last_value  out  16  last word actually written to the RAM.

Behaviour:
- Reset (clr=0, async): state=IDLE, idx=0, bank_r=0, sum_r=0, last_value=0, overflow=0. All outputs are 0 immediately (w0=w1=0 with no clock edge required).
- RAM-port outputs are combinational decodes of state, bank_r, idx and sum_r.
- IDLE:
  - All RAM outputs 0.
  - start=1 → capture bank_r=bank, clear overflow, go to SEED.
- SEED (1 cycle):
  - w0=1, addr0={bank_r,10'd0}, data0=SEED0.
  - w1=1, addr1={bank_r,10'd1}, data1=SEED1.
  - Set last_value=SEED1, idx=2, go to READ.
- READ (1 cycle):
  - w0=w1=0, addr0={bank_r,idx-2}, addr1={bank_r,idx-1}, data0=data1=0.
  - The RAM reads at the mid-cycle rising edge, so q0/q1 are valid at the closing falling edge.
  - At that edge: 17-bit sum = q0+q1.
  - If sum[16]=1 → overflow=1, go to DONE with no write.
  - Otherwise sum_r=sum[15:0], go to WRITE.
- WRITE (1 cycle):
  - w0=1, addr0={bank_r,idx}, data0=sum_r; w1=0, addr1=0, data1=0.
  - At the closing edge: last_value=sum_r.
  - If idx==NUM_TERMS-1 → DONE; else idx=idx+1 and go to READ.
- DONE (1 cycle):
  - done=1, busy=0, all RAM outputs 0. Go to IDLE.
- Latency, start accepted to done pulse: 1 + 2*(NUM_TERMS-2) cycles. Default is 47 cycles; done is high in cycle 48.
- Width rules:
  - idx is 10 bits; the subtractions idx-2 and idx-1 never underflow because idx≥2 in READ.
  - idx never wraps because NUM_TERMS≤1024.
- start held high through DONE → a new run begins from IDLE on the next cycle; there is no back-to-back run from DONE itself.
- start or bank changes while busy have no effect; bank_r stays fixed for the whole run.
- Reset mid-run:
  - Aborts immediately; the next start restarts from SEED.
  - Partially written RAM contents are left unchanged.

Test Plan:
- Default run, bank=5'd3, start pulse → 1 seed cycle then 23 READ/WRITE pairs. RAM[3072..3096] = 0,1,1,2,3,5,...,46368. done pulses in cycle 48, last_value=46368, overflow=0.
- NUM_TERMS=27 → WRITE at idx 24 stores 46368. READ at idx 25 computes 75025 (bit 16 set), so there is no write to offset 25. Expect overflow=1, done pulse, last_value=46368, RAM[offset 25] unchanged.
- During a run, toggle start and change bank to 5'd7 → no effect. All writes stay in bank 3; cycle count is still 48.
- Drop clr low between falling edges while in WRITE → w0 goes 0 within the same half-cycle; all outputs are 0. A new start then rewrites from offset 0.
- NUM_TERMS=3, SEED0=16'd5, SEED1=16'd7, bank=5'd31 → writes RAM[31744]=5, RAM[31745]=7, RAM[31746]=12. done is high in cycle 4, last_value=12.
- Hold start=1 continuously → runs repeat with exactly one IDLE cycle between the DONE pulse and the next SEED cycle.

Source files
------------

// File: rtl/fib_mem_sequencer_if.sv
// RAM-port and start/done handshake bundle for the Fibonacci sequencer.
// The master side is the sequencer; the slave side is the RAM/top-level mux.
interface fib_mem_sequencer_if;
  logic        start;
  logic [4:0]  bank;
  logic [15:0] q0;
  logic [15:0] q1;
  logic [14:0] addr0;
  logic [14:0] addr1;
  logic        w0;
  logic        w1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] last_value;

  modport master (
    input  start, bank, q0, q1,
    output addr0, addr1, w0, w1, data0, data1, busy, done, overflow, last_value
  );

  modport slave (
    output start, bank, q0, q1,
    input  addr0, addr1, w0, w1, data0, data1, busy, done, overflow, last_value
  );
endinterface

// File: rtl/fib_mem_sequencer.sv
// Writes a Fibonacci sequence into one 1K-word bank of a dual-port RAM.
// State advances on the falling clock edge so the RAM can sample on the rising edge.
module fib_mem_sequencer #(
  parameter int unsigned NUM_TERMS = 25,
  parameter logic [15:0] SEED0     = 16'd0,
  parameter logic [15:0] SEED1     = 16'd1
) (
  input logic                 clk,
  input logic                 clr,
  fib_mem_sequencer_if.master bus_io
);

  localparam logic [9:0] LastIdx = 10'(NUM_TERMS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e      state_q;
  logic [9:0]  idx_q;
  logic [4:0]  bank_q;
  logic [15:0] sum_q;
  logic [15:0] last_q;
  logic        ovf_q;
  logic [16:0] sum;

  // q0/q1 hold the two previous terms by the closing edge of a READ cycle.
  assign sum = {1'b0, bus_io.q0} + {1'b0, bus_io.q1};

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      idx_q   <= '0;
      bank_q  <= '0;
      sum_q   <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            bank_q  <= bus_io.bank;
            ovf_q   <= 1'b0;
            state_q <= StSeed;
          end
        end
        StSeed: begin
          last_q  <= SEED1;
          idx_q   <= 10'd2;
          state_q <= StRead;
        end
        StRead: begin
          if (sum[16]) begin
            ovf_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            sum_q   <= sum[15:0];
            state_q <= StWrite;
          end
        end
        StWrite: begin
          last_q <= sum_q;
          if (idx_q == LastIdx) begin
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 10'd1;
            state_q <= StRead;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    bus_io.addr0 = '0;
    bus_io.addr1 = '0;
    bus_io.w0    = 1'b0;
    bus_io.w1    = 1'b0;
    bus_io.data0 = '0;
    bus_io.data1 = '0;
    bus_io.busy  = 1'b0;
    bus_io.done  = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StSeed: begin
        bus_io.w0    = 1'b1;
        bus_io.addr0 = {bank_q, 10'd0};
        bus_io.data0 = SEED0;
        bus_io.w1    = 1'b1;
        bus_io.addr1 = {bank_q, 10'd1};
        bus_io.data1 = SEED1;
        bus_io.busy  = 1'b1;
      end
      StRead: begin
        // idx_q >= 2 here, so neither subtraction can underflow.
        bus_io.addr0 = {bank_q, idx_q - 10'd2};
        bus_io.addr1 = {bank_q, idx_q - 10'd1};
        bus_io.busy  = 1'b1;
      end
      StWrite: begin
        bus_io.w0    = 1'b1;
        bus_io.addr0 = {bank_q, idx_q};
        bus_io.data0 = sum_q;
        bus_io.busy  = 1'b1;
      end
      StDone: begin
        bus_io.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus_io.overflow   = ovf_q;
  assign bus_io.last_value = last_q;

endmodule

// File: tb/tb_fib_mem_sequencer.sv
// Scoreboard bench: three sequencer instances (default, overflowing, short) each on its own RAM.
// Stimulus pushes expected runs; a single monitor pops them and checks writes, timing and RAM.
module tb_fib_mem_sequencer;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    logic [4:0]  bank;
    int          nw;
    logic [15:0] last;
    logic        ovf;
    int          done_cyc;
    bit          gap;
  } exp_t;

  logic                 clk;
  logic                 clr;
  logic [NI-1:0]        start_v;
  logic [NI-1:0][4:0]   bank_v;
  logic [NI-1:0][15:0]  q0_v;
  logic [NI-1:0][15:0]  q1_v;
  logic [NI-1:0][14:0]  addr0_v;
  logic [NI-1:0][14:0]  addr1_v;
  logic [NI-1:0]        w0_v;
  logic [NI-1:0]        w1_v;
  logic [NI-1:0][15:0]  data0_v;
  logic [NI-1:0][15:0]  data1_v;
  logic [NI-1:0]        busy_v;
  logic [NI-1:0]        done_v;
  logic [NI-1:0]        ovf_v;
  logic [NI-1:0][15:0]  last_v;

  logic [15:0] mem [NI][32768];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NT = (g == 0) ? 25 : (g == 1) ? 27 : 3;
    localparam logic [15:0] S0 = (g == 2) ? 16'd5 : 16'd0;
    localparam logic [15:0] S1 = (g == 2) ? 16'd7 : 16'd1;

    fib_mem_sequencer_if bus ();

    assign bus.start  = start_v[g];
    assign bus.bank   = bank_v[g];
    assign bus.q0     = q0_v[g];
    assign bus.q1     = q1_v[g];
    assign addr0_v[g] = bus.addr0;
    assign addr1_v[g] = bus.addr1;
    assign w0_v[g]    = bus.w0;
    assign w1_v[g]    = bus.w1;
    assign data0_v[g] = bus.data0;
    assign data1_v[g] = bus.data1;
    assign busy_v[g]  = bus.busy;
    assign done_v[g]  = bus.done;
    assign ovf_v[g]   = bus.overflow;
    assign last_v[g]  = bus.last_value;

    fib_mem_sequencer #(
      .NUM_TERMS(NT),
      .SEED0    (S0),
      .SEED1    (S1)
    ) u_dut (
      .clk   (clk),
      .clr   (clr),
      .bus_io(bus)
    );
  end

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Synchronous-read dual-port RAM; a read returns the pre-write contents.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (w0_v[k]) mem[k][addr0_v[k]] <= data0_v[k];
      if (w1_v[k]) mem[k][addr1_v[k]] <= data1_v[k];
      q0_v[k] <= mem[k][addr0_v[k]];
      q1_v[k] <= mem[k][addr1_v[k]];
    end
  end

  // Reference model: the sequence each instance should produce.
  logic [15:0] exp_vals [NI][1024];
  int          exp_nw   [NI];
  logic        exp_ovf  [NI];
  exp_t        sb_q[$];
  int          timeouts;
  bit          stim_done;

  function automatic void build(input int k, input int nt, input int s0, input int s1);
    int  i;
    int  sum;
    bit  stop;
    exp_vals[k][0] = 16'(s0);
    exp_vals[k][1] = 16'(s1);
    exp_ovf[k]     = 1'b0;
    stop           = 1'b0;
    i              = 2;
    while (i < nt && !stop) begin
      sum = int'(exp_vals[k][i-2]) + int'(exp_vals[k][i-1]);
      if (sum > 65535) begin
        exp_ovf[k] = 1'b1;
        stop       = 1'b1;
      end else begin
        exp_vals[k][i] = 16'(sum);
        i++;
      end
    end
    exp_nw[k] = i;
  endfunction

  task automatic push_rec(input int k, input logic [4:0] b, input bit gap);
    exp_t r;
    r.inst     = k;
    r.bank     = b;
    r.nw       = exp_nw[k];
    r.last     = exp_vals[k][exp_nw[k]-1];
    r.ovf      = exp_ovf[k];
    r.done_cyc = 1 + 2 * (exp_nw[k] - 2) + (exp_ovf[k] ? 1 : 0) + 1;
    r.gap      = gap;
    sb_q.push_back(r);
  endtask

  task automatic launch(input int k, input logic [4:0] b);
    @(negedge clk);
    #2;
    bank_v[k]  = b;
    start_v[k] = 1'b1;
    push_rec(k, b, 1'b0);
    @(negedge clk);
    #2;
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input bit disturb);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
      if (!done_v[k] && disturb) begin
        start_v[k] = 1'($urandom_range(0, 1));
        bank_v[k]  = 5'($urandom);
      end
    end while (!done_v[k] && n < 400);
    if (!done_v[k]) timeouts++;
    if (disturb) start_v[k] = 1'b0;
  endtask

  initial begin
    int n;
    int wc;
    clr       = 1'b0;
    start_v   = '0;
    bank_v    = '0;
    timeouts  = 0;
    stim_done = 1'b0;
    build(0, 25, 0, 1);
    build(1, 27, 0, 1);
    build(2, 3, 5, 7);
    repeat (3) @(negedge clk);
    #2;
    clr = 1'b1;

    launch(0, 5'd3);
    wait_done(0, 1'b0);
    launch(0, 5'd3);
    wait_done(0, 1'b1);
    launch(1, 5'd3);
    wait_done(1, 1'b0);
    launch(2, 5'd31);
    wait_done(2, 1'b0);
    launch(1, 5'd9);
    wait_done(1, 1'b0);

    // Abort in the fifth WRITE cycle, then rerun the same bank from scratch.
    launch(0, 5'd3);
    n  = 0;
    wc = 0;
    while (wc < 5 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
      if (w0_v[0] && !w1_v[0]) wc++;
    end
    if (wc < 5) timeouts++;
    clr = 1'b0;
    @(negedge clk);
    #2;
    clr = 1'b1;
    launch(0, 5'd3);
    wait_done(0, 1'b0);

    // Start held high: three back-to-back runs separated by one IDLE cycle.
    @(negedge clk);
    #2;
    bank_v[2]  = 5'd12;
    start_v[2] = 1'b1;
    push_rec(2, 5'd12, 1'b0);
    push_rec(2, 5'd12, 1'b1);
    push_rec(2, 5'd12, 1'b1);
    repeat (3) wait_done(2, 1'b0);
    start_v[2] = 1'b0;

    repeat (12) begin
      int         k;
      logic [4:0] b;
      k = $urandom_range(0, NI - 1);
      b = 5'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(k, b);
      wait_done(k, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    stim_done = 1'b1;
  end

  // Monitor / scoreboard.
  int          n_checks;
  int          n_fail;
  int          samples;
  bit          running     [NI];
  exp_t        cur         [NI];
  int          cyc         [NI];
  int          wcnt        [NI];
  logic [15:0] snap        [NI];
  int          last_done_s [NI];

  task automatic chk(input bit ok, input string name, input int k, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", name, k, $time, act, req);
    end
  endtask

  task automatic check_write(input int k, input logic [14:0] a, input logic [15:0] d);
    logic [9:0] off;
    off = a[9:0];
    if (!running[k]) begin
      chk(1'b0, "write_while_idle", k, int'(a), -1);
    end else begin
      chk(a[14:10] == cur[k].bank, "write_bank", k, int'(a[14:10]), int'(cur[k].bank));
      chk(int'(off) < cur[k].nw && d == exp_vals[k][off], "write_data", k, int'(d),
          (int'(off) < cur[k].nw) ? int'(exp_vals[k][off]) : -1);
      wcnt[k]++;
    end
  endtask

  task automatic mon_inst(input int k);
    bit exp_done;
    int bad;
    if (w0_v[k] && w1_v[k]) begin
      if (running[k]) begin
        chk(1'b0, "seed_during_run", k, cyc[k], -1);
      end else if (sb_q.size() == 0) begin
        chk(1'b0, "unexpected_seed", k, 1, 0);
      end else begin
        cur[k] = sb_q.pop_front();
        chk(cur[k].inst == k, "seed_instance", k, k, cur[k].inst);
        if (cur[k].gap) chk(samples - last_done_s[k] == 2, "restart_gap", k,
                            samples - last_done_s[k], 2);
        running[k] = 1'b1;
        cyc[k]     = 0;
        wcnt[k]    = 0;
        if (cur[k].nw < 1024) snap[k] = mem[k][{cur[k].bank, 10'(cur[k].nw)}];
      end
    end
    if (running[k]) cyc[k]++;
    if (w0_v[k]) check_write(k, addr0_v[k], data0_v[k]);
    if (w1_v[k]) check_write(k, addr1_v[k], data1_v[k]);
    exp_done = running[k] && cyc[k] == cur[k].done_cyc;
    chk(busy_v[k] == (running[k] && !exp_done), "busy", k, int'(busy_v[k]),
        int'(running[k] && !exp_done));
    chk(done_v[k] == exp_done, "done", k, int'(done_v[k]), int'(exp_done));
    if (exp_done) begin
      chk(last_v[k] == cur[k].last, "last_value", k, int'(last_v[k]), int'(cur[k].last));
      chk(ovf_v[k] == cur[k].ovf, "overflow", k, int'(ovf_v[k]), int'(cur[k].ovf));
      chk(wcnt[k] == cur[k].nw, "write_count", k, wcnt[k], cur[k].nw);
      bad = -1;
      for (int o = 0; o < cur[k].nw; o++) begin
        if (bad < 0 && mem[k][{cur[k].bank, 10'(o)}] != exp_vals[k][o]) bad = o;
      end
      chk(bad < 0, "ram_content_offset", k, bad, -1);
      if (cur[k].nw < 1024) begin
        chk(mem[k][{cur[k].bank, 10'(cur[k].nw)}] == snap[k], "ram_untouched", k,
            int'(mem[k][{cur[k].bank, 10'(cur[k].nw)}]), int'(snap[k]));
      end
      running[k]     = 1'b0;
      last_done_s[k] = samples;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    samples  = 0;
    for (int k = 0; k < NI; k++) begin
      running[k]     = 1'b0;
      cyc[k]         = 0;
      wcnt[k]        = 0;
      last_done_s[k] = 0;
    end
    forever begin
      @(posedge clk or negedge clr);
      #1;
      if (!clr) begin
        for (int k = 0; k < NI; k++) begin
          running[k] = 1'b0;
          chk({w0_v[k], w1_v[k], busy_v[k], done_v[k], ovf_v[k]} == 5'd0 &&
              addr0_v[k] == '0 && addr1_v[k] == '0 && data0_v[k] == '0 &&
              data1_v[k] == '0 && last_v[k] == '0, "reset_outputs", k,
              int'({w0_v[k], w1_v[k], busy_v[k], done_v[k], ovf_v[k]}), 0);
        end
      end else begin
        samples++;
        for (int k = 0; k < NI; k++) mon_inst(k);
      end
      if (stim_done) begin
        chk(timeouts == 0, "wait_timeouts", 0, timeouts, 0);
        chk(sb_q.size() == 0, "scoreboard_drained", 0, sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
      if (samples > 60000) begin
        n_fail++;
        $display("FAIL watchdog: got %0d cycles, expected at most 60000", samples);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

endmodule
